// File: rtl/red_pitaya_scope_acq_ctrl.sv
// Acquisition sequencer for one scope capture buffer: arm, pre-trigger fill,
// trigger acceptance, post-trigger delay and completion, plus RAM write pointer.
module red_pitaya_scope_acq_ctrl #(
    parameter int RSZ  = 14,
    parameter int TW   = 32,
    parameter int NTRG = 8
) (
    input  logic            adc_clk_i,
    input  logic            adc_rst_i,
    input  logic            arm_i,
    input  logic            abort_i,
    input  logic [3:0]      trig_sel_i,
    input  logic [NTRG-1:0] trig_vec_i,
    input  logic [RSZ-1:0]  pre_i,
    input  logic [TW-1:0]   dly_i,
    input  logic            smp_vld_i,
    output logic            wen_o,
    output logic [RSZ-1:0]  wptr_o,
    output logic [RSZ-1:0]  tptr_o,
    output logic            trig_o,
    output logic            armed_o,
    output logic            trigd_o,
    output logic            done_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]     r_state;
    logic [RSZ-1:0] r_wptr;
    logic [RSZ-1:0] r_tptr;
    logic [RSZ-1:0] r_pre_cnt;
    logic [TW-1:0]  r_post_cnt;
    logic           r_trig;

    logic           w_active;
    logic           w_trig_hit;
    logic [RSZ-1:0] w_pre_nxt;

    // Pre-trigger count stops at the top so a huge pre_i cannot wrap it.
    function automatic logic [RSZ-1:0] sat_inc(input logic [RSZ-1:0] v);
        if (&v) begin
            return v;
        end
        return v + RSZ'(1);
    endfunction

    // Select 0 and any select above NTRG match no source.
    always_comb begin
        w_trig_hit = 1'b0;
        for (int k = 0; k < NTRG; k++) begin
            if ((trig_sel_i == 4'(k + 1)) && trig_vec_i[k]) begin
                w_trig_hit = 1'b1;
            end
        end
    end

    assign w_active  = (r_state == ST_FILL) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_pre_nxt = sat_inc(r_pre_cnt);

    // Write enable depends only on registered state and the sample strobe.
    assign wen_o   = smp_vld_i & w_active;
    assign wptr_o  = r_wptr;
    assign tptr_o  = r_tptr;
    assign trig_o  = r_trig;
    assign armed_o = w_active;
    assign trigd_o = (r_state == ST_POST) || (r_state == ST_DONE);
    assign done_o  = (r_state == ST_DONE);

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_tptr     <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            if (abort_i) begin
                r_state <= ST_IDLE;
            end else if (arm_i) begin
                // Restart from address 0; a coincident trigger is deliberately dropped.
                r_wptr    <= '0;
                r_pre_cnt <= '0;
                r_state   <= (pre_i != '0) ? ST_FILL : ST_WAIT;
            end else begin
                if (wen_o) begin
                    r_wptr <= r_wptr + RSZ'(1);
                end
                case (r_state)
                    ST_FILL: begin
                        if (wen_o) begin
                            r_pre_cnt <= w_pre_nxt;
                            if (w_pre_nxt == pre_i) begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        // The trigger-cycle write is the trigger sample, not a post sample.
                        if (w_trig_hit) begin
                            r_tptr     <= r_wptr;
                            r_trig     <= 1'b1;
                            r_post_cnt <= dly_i;
                            r_state    <= (dly_i == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (wen_o) begin
                            r_post_cnt <= r_post_cnt - TW'(1);
                            if (r_post_cnt == TW'(1)) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_scope_acq_ctrl.sv
// Bench for red_pitaya_scope_acq_ctrl: two instances (RSZ=14 and RSZ=4) share
// stimulus and are compared against an unbounded-counter reference model.
module tb_red_pitaya_scope_acq_ctrl;

    localparam int NTRG = 8;
    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_WAIT = 2;
    localparam int P_POST = 3;
    localparam int P_DONE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, arm, abort, smp;
    logic [3:0]  sel;
    logic [7:0]  vec;
    logic [13:0] pre;
    logic [3:0]  pre4;
    logic [31:0] dly;
    assign pre4 = pre[3:0];

    logic        wen, trig, armed, trigd, done;
    logic [13:0] wptr, tptr;
    logic        wen4, trig4, armed4, trigd4, done4;
    logic [3:0]  wptr4, tptr4;

    red_pitaya_scope_acq_ctrl #(.RSZ(14), .TW(32), .NTRG(NTRG)) dut (
        .adc_clk_i(clk), .adc_rst_i(rst), .arm_i(arm), .abort_i(abort),
        .trig_sel_i(sel), .trig_vec_i(vec), .pre_i(pre), .dly_i(dly),
        .smp_vld_i(smp), .wen_o(wen), .wptr_o(wptr), .tptr_o(tptr),
        .trig_o(trig), .armed_o(armed), .trigd_o(trigd), .done_o(done)
    );

    red_pitaya_scope_acq_ctrl #(.RSZ(4), .TW(32), .NTRG(NTRG)) dut4 (
        .adc_clk_i(clk), .adc_rst_i(rst), .arm_i(arm), .abort_i(abort),
        .trig_sel_i(sel), .trig_vec_i(vec), .pre_i(pre4), .dly_i(dly),
        .smp_vld_i(smp), .wen_o(wen4), .wptr_o(wptr4), .tptr_o(tptr4),
        .trig_o(trig4), .armed_o(armed4), .trigd_o(trigd4), .done_o(done4)
    );

    int total = 0;
    int bad = 0;

    // Reference model: writes since arm counted without bound, address = count mod depth.
    int     depth [2] = '{16384, 16};
    int     m_phase [2];
    longint m_nwr [2];
    int     m_filled [2];
    longint m_post [2];
    int     m_tptr [2];
    bit     m_trig [2];

    bit exp_wen [2];
    bit obs_wen [2];
    int last_wa [2];
    int nwen [2];
    int wraps [2];

    function automatic bit sel_hit();
        int s;
        s = int'(sel);
        if (s >= 1 && s <= NTRG) return vec[s-1];
        return 1'b0;
    endfunction

    function automatic bit e_armed(input int i);
        return (m_phase[i] == P_FILL) || (m_phase[i] == P_WAIT) || (m_phase[i] == P_POST);
    endfunction

    function automatic bit e_trigd(input int i);
        return (m_phase[i] == P_POST) || (m_phase[i] == P_DONE);
    endfunction

    function automatic int e_wptr(input int i);
        return int'(m_nwr[i] % longint'(depth[i]));
    endfunction

    task automatic model_update(input int i);
        int p, sat;
        bit w;
        longint addr;
        p = (i == 0) ? int'(pre) : int'(pre4);
        w = exp_wen[i];
        addr = m_nwr[i] % longint'(depth[i]);
        m_trig[i] = 1'b0;
        if (rst) begin
            m_phase[i] = P_IDLE; m_nwr[i] = 0; m_filled[i] = 0; m_post[i] = 0; m_tptr[i] = 0;
        end else if (abort) begin
            m_phase[i] = P_IDLE;
        end else if (arm) begin
            m_nwr[i] = 0; m_filled[i] = 0;
            m_phase[i] = (p != 0) ? P_FILL : P_WAIT;
        end else begin
            if (w) m_nwr[i]++;
            case (m_phase[i])
                P_FILL: if (w) begin
                    m_filled[i]++;
                    sat = (m_filled[i] < depth[i] - 1) ? m_filled[i] : depth[i] - 1;
                    if (sat == p) m_phase[i] = P_WAIT;
                end
                P_WAIT: if (sel_hit()) begin
                    m_tptr[i] = int'(addr);
                    m_trig[i] = 1'b1;
                    m_post[i] = longint'(dly);
                    m_phase[i] = (dly == 0) ? P_DONE : P_POST;
                end
                P_POST: if (w) begin
                    m_post[i]--;
                    if (m_post[i] == 0) m_phase[i] = P_DONE;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: observe write strobes mid-cycle, advance model at the edge, settle.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) exp_wen[i] = smp && e_armed(i);
        obs_wen[0] = wen;
        obs_wen[1] = wen4;
        if (wen) begin
            last_wa[0] = int'(wptr); nwen[0]++;
            if (wptr == 14'h3fff) wraps[0]++;
        end
        if (wen4) begin
            last_wa[1] = int'(wptr4); nwen[1]++;
            if (wptr4 == 4'hf) wraps[1]++;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_update(i);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            smp = c[0];
            tick();
        end
        total++;
        if ({wptr, tptr, trig, armed, trigd, done} !== 32'd0) begin
            bad++; $display("FAIL reset_state got=%h exp=0", {wptr, tptr, trig, armed, trigd, done});
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            smp = ~smp;
            tick();
            total++;
            if ({obs_wen[0], wptr, armed, done} !== 17'd0) begin
                bad++; $display("FAIL idle_quiet got=%h exp=0", {obs_wen[0], wptr, armed, done});
            end
        end
    endtask

    task automatic test_pretrig_fill();
        pre = 14'd10; dly = 32'd20; sel = 4'd1; smp = 1'b1; vec = 8'h00;
        arm = 1'b1; tick(); arm = 1'b0;
        nwen[0] = 0;
        for (int k = 0; k <= 35; k++) begin
            vec = (k == 5 || k == 15) ? 8'h01 : 8'h00;
            tick();
            if (k == 5) begin
                total++;
                if ({trig, armed, trigd} !== 3'b010) begin
                    bad++; $display("FAIL fill_ignores_trig got=%b exp=010", {trig, armed, trigd});
                end
            end
            if (k == 15) begin
                total++;
                if ({trig, trigd, tptr} !== {2'b11, 14'd15}) begin
                    bad++; $display("FAIL accept_trig got=%h exp=%h", {trig, trigd, tptr}, {2'b11, 14'd15});
                end
            end
            if (k == 16) begin
                total++;
                if (trig !== 1'b0) begin
                    bad++; $display("FAIL trig_one_cycle got=%b exp=0", trig);
                end
            end
            if (k == 34) begin
                total++;
                if (done !== 1'b0) begin
                    bad++; $display("FAIL done_early got=%b exp=0", done);
                end
            end
        end
        vec = 8'h00;
        total++;
        if (done !== 1'b1 || last_wa[0] != 35 || nwen[0] != 36 || wptr !== 14'd36) begin
            bad++; $display("FAIL post_count done=%b last=%0d n=%0d wptr=%0d exp 1/35/36/36", done, last_wa[0], nwen[0], wptr);
        end
        tick();
        total++;
        if (obs_wen[0] !== 1'b0 || wptr !== 14'd36 || done !== 1'b1) begin
            bad++; $display("FAIL done_holds wen=%b wptr=%0d done=%b exp 0/36/1", obs_wen[0], wptr, done);
        end
    endtask

    task automatic test_zero_pre_dly();
        pre = 14'd0; dly = 32'd0; sel = 4'd7; smp = 1'b1; vec = 8'h00;
        arm = 1'b1; tick(); arm = 1'b0;
        nwen[0] = 0;
        total++;
        if ({armed, trigd} !== 2'b10) begin
            bad++; $display("FAIL direct_wait got=%b exp=10", {armed, trigd});
        end
        for (int c = 0; c < 3; c++) tick();
        vec = 8'h40; tick(); vec = 8'h00;
        total++;
        if ({trig, done, tptr, wptr} !== {2'b11, 14'd3, 14'd4} || nwen[0] != 4) begin
            bad++; $display("FAIL zero_dly trig=%b done=%b tptr=%0d wptr=%0d n=%0d exp 1/1/3/4/4", trig, done, tptr, wptr, nwen[0]);
        end
    endtask

    task automatic test_wrap();
        pre = 14'd2; dly = 32'd40; sel = 4'd1; smp = 1'b0; vec = 8'h00;
        arm = 1'b1; tick(); arm = 1'b0;
        nwen[1] = 0; wraps[1] = 0;
        for (int c = 0; c < 200 && !done4; c++) begin
            smp = (c % 2 == 0);
            vec = (c == 10) ? 8'h01 : 8'h00;
            tick();
            if (c == 10) begin
                total++;
                if ({trig4, tptr4} !== {1'b1, 4'd5}) begin
                    bad++; $display("FAIL wrap_trig got=%h exp=%h", {trig4, tptr4}, {1'b1, 4'd5});
                end
            end
        end
        vec = 8'h00; smp = 1'b1;
        total++;
        if (done4 !== 1'b1 || last_wa[1] != 13 || wraps[1] != 2 || nwen[1] != 46) begin
            bad++; $display("FAIL wrap_done done=%b last=%0d wraps=%0d n=%0d exp 1/13/2/46", done4, last_wa[1], wraps[1], nwen[1]);
        end
    endtask

    task automatic test_abort_rearm();
        pre = 14'd0; dly = 32'd20; sel = 4'd1; smp = 1'b1; vec = 8'h00;
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        vec = 8'h01; tick(); vec = 8'h00;
        for (int c = 0; c < 7; c++) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        total++;
        if ({armed, trigd, done, tptr, wptr} !== {3'b000, 14'd2, 14'd10}) begin
            bad++; $display("FAIL abort got=%b%b%b tptr=%0d wptr=%0d exp 000/2/10", armed, trigd, done, tptr, wptr);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs_wen[0] !== 1'b0 || wptr !== 14'd10) begin
                bad++; $display("FAIL after_abort wen=%b wptr=%0d exp 0/10", obs_wen[0], wptr);
            end
        end
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick();
        arm = 1'b1; vec = 8'h01; tick(); arm = 1'b0; vec = 8'h00;
        total++;
        if ({trig, armed, trigd, wptr, tptr} !== {3'b010, 14'd0, 14'd2}) begin
            bad++; $display("FAIL rearm_with_trig trig=%b armed=%b trigd=%b wptr=%0d tptr=%0d exp 0/1/0/0/2", trig, armed, trigd, wptr, tptr);
        end
    endtask

    task automatic test_no_source();
        int hits;
        pre = 14'd0; dly = 32'd5; sel = 4'd0; vec = 8'h00;
        arm = 1'b1; tick(); arm = 1'b0;
        hits = 0;
        for (int c = 0; c < 1000; c++) begin
            smp = 1'($urandom);
            vec = 8'($urandom) | 8'h01;
            tick();
            if (trig || trigd) hits++;
        end
        total++;
        if (hits != 0 || armed !== 1'b1) begin
            bad++; $display("FAIL sel0 hits=%0d armed=%b exp 0/1", hits, armed);
        end
        hits = 0;
        for (int s = 9; s < 16; s++) begin
            sel = 4'(s);
            for (int c = 0; c < 60; c++) begin
                smp = 1'($urandom);
                vec = 8'hff;
                tick();
                if (trig || trigd) hits++;
            end
        end
        vec = 8'h00;
        total++;
        if (hits != 0 || armed !== 1'b1) begin
            bad++; $display("FAIL sel_over hits=%0d armed=%b exp 0/1", hits, armed);
        end
    endtask

    task automatic test_random();
        logic [32:0] got0, exp0;
        logic [12:0] got1, exp1;
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom % 600 == 0);
            arm   = ($urandom % 40 == 0);
            abort = ($urandom % 90 == 0);
            sel   = 4'($urandom % 16);
            vec   = ($urandom % 5 == 0) ? 8'($urandom) : 8'h00;
            smp   = ($urandom % 3 != 0);
            if ($urandom % 50 == 0) pre = 14'($urandom % 20);
            if ($urandom % 30 == 0) dly = ($urandom % 8 == 0) ? ($urandom % 200) : ($urandom % 12);
            tick();
            got0 = {obs_wen[0], wptr, tptr, trig, armed, trigd, done};
            exp0 = {exp_wen[0], 14'(e_wptr(0)), 14'(m_tptr[0]), m_trig[0], e_armed(0), e_trigd(0), m_phase[0] == P_DONE};
            total++;
            if (got0 !== exp0) begin
                bad++; $display("FAIL rand_rsz14 cyc=%0d got=%h exp=%h", c, got0, exp0);
            end
            got1 = {obs_wen[1], wptr4, tptr4, trig4, armed4, trigd4, done4};
            exp1 = {exp_wen[1], 4'(e_wptr(1)), 4'(m_tptr[1]), m_trig[1], e_armed(1), e_trigd(1), m_phase[1] == P_DONE};
            total++;
            if (got1 !== exp1) begin
                bad++; $display("FAIL rand_rsz4 cyc=%0d got=%h exp=%h", c, got1, exp1);
            end
        end
        rst = 1'b0; arm = 1'b0; abort = 1'b0; vec = 8'h00;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; smp = 1'b0;
        sel = 4'd0; vec = 8'h00; pre = 14'd0; dly = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_nwr[i] = 0; m_filled[i] = 0; m_post[i] = 0;
            m_tptr[i] = 0; m_trig[i] = 0; exp_wen[i] = 0; obs_wen[i] = 0;
            last_wa[i] = -1; nwen[i] = 0; wraps[i] = 0;
        end
        @(posedge clk); #1;
        test_reset();
        test_pretrig_fill();
        test_zero_pre_dly();
        test_wrap();
        test_abort_rearm();
        test_no_source();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_pitaya_scope_acq_ctrl.md
Name: red_pitaya_scope_acq_ctrl

Overview:
Acquisition sequencer for one oscilloscope capture buffer. It handles arm, pre-trigger fill, trigger acceptance from a selectable source, post-trigger delay counting and completion. It generates write enables and a wrapping write pointer for the 2**RSZ sample RAM, and latches the trigger position. It sits between the decimator output strobe and the scope capture RAMs and status registers, and is shared by both channels.

Parameters:
RSZ, 14, RAM address width; buffer holds 2**RSZ samples
TW, 32, post-trigger delay counter width
NTRG, 8, number of trigger sources in trig_vec_i

Ports:
adc_clk_i  in  1  ADC clock
adc_rst_i  in  1  reset, synchronous, active-high
arm_i  in  1  single-cycle pulse: start a new acquisition
abort_i  in  1  single-cycle pulse: stop the acquisition and return to idle
trig_sel_i  in  4  trigger source: 0 = none; k = 1..NTRG selects trig_vec_i[k-1]; values above NTRG = none
trig_vec_i  in  NTRG  edge-detected trigger pulses (bit0 = software trigger)
pre_i  in  RSZ  minimum pre-trigger samples written before a trigger is accepted
dly_i  in  TW  samples written after the trigger sample
smp_vld_i  in  1  decimated sample strobe
wen_o  out  1  buffer write enable
wptr_o  out  RSZ  buffer write address
tptr_o  out  RSZ  write address of the trigger sample
trig_o  out  1  single-cycle pulse when a trigger is accepted (used to auto-clear the source select)
armed_o  out  1  high in FILL, WAIT and POST
trigd_o  out  1  high in POST and DONE
done_o  out  1  high in DONE

Behaviour:
- States: IDLE, FILL, WAIT, POST, DONE. Single registered state machine.
- Reset: state = IDLE. wptr_o, tptr_o, pre counter and post counter = 0. trig_o = 0.
- Status decode is registered-state based: armed_o, trigd_o, done_o change 1 cycle after the causing input.
- wen_o is combinational: smp_vld_i & (state in FILL, WAIT, POST).
- wptr_o:
  - cleared to 0 on an accepted arm;
  - incremented by 1 every cycle wen_o=1;
  - wraps from 2**RSZ-1 to 0;
  - wptr_o is the address of the current write.
- Event priority in one cycle: adc_rst_i > abort_i > arm_i > trigger > sample counting.
- abort_i in any state -> IDLE next cycle. wptr_o and tptr_o hold their values.
- arm_i in any state (including FILL, WAIT, POST, DONE):
  - restart: wptr_o=0, pre counter=0, tptr_o holds;
  - next state = FILL if pre_i != 0, else WAIT;
  - a trigger pulse in the same cycle as arm_i is ignored.
- FILL:
  - pre counter increments per write, saturating at 2**RSZ-1;
  - when the count after this cycle's write equals pre_i -> WAIT;
  - triggers are ignored in FILL.
- WAIT: a trigger is accepted when the selected source bit is 1 (trig_sel_i in 1..NTRG); trig_sel_i = 0 never triggers. On acceptance:
  - tptr_o <= wptr_o (current cycle's address, regardless of smp_vld_i);
  - trig_o = 1 for one cycle;
  - post counter <= dly_i;
  - next state = DONE if dly_i = 0, else POST.
  - The trigger-cycle write (if smp_vld_i) still occurs and counts as the trigger sample, not a post sample.
- POST:
  - post counter decrements per write;
  - the write that brings it to 0 is the last write, then DONE next cycle;
  - exactly dly_i post-trigger writes occur;
  - trigger inputs are ignored.
- DONE: no writes; holds until arm_i or abort_i.
- dly_i, pre_i and trig_sel_i are sampled at use (pre_i compared live, dly_i loaded at trigger). Changing them mid-acquisition affects only later comparisons/loads.
- dly_i >= 2**RSZ is legal: the buffer overwrites, wptr_o keeps wrapping, and tptr_o data may be overwritten (software responsibility).
- No output is X after reset. No combinational path from trig_vec_i to wen_o.

Test Plan:
1. Reset for 4 cycles, then idle -> wen_o=0, wptr_o=0, armed_o=0, done_o=0 while smp_vld_i toggles.
2. pre_i=10, dly_i=20, trig_sel_i=1, smp_vld_i=1 continuous, arm; software trigger pulse on sample 5 and again on sample 15:
   - first pulse ignored (FILL);
   - second pulse accepted: tptr_o=15, trig_o for 1 cycle;
   - 20 further writes; done_o rises with last wptr_o=35.
3. pre_i=0, dly_i=0, trig_sel_i=7, pulse trig_vec_i[6] 3 cycles after arm -> WAIT directly after arm, tptr_o=3, DONE next cycle, total writes = 4.
4. RSZ=4, pre_i=2, dly_i=40, smp_vld_i every other cycle, trigger at wptr 5 -> wptr_o wraps 15->0 twice, last write at address (5+40) mod 16 = 13, done_o=1.
5. Abort in POST after 7 post writes -> IDLE next cycle, wen_o=0 thereafter, tptr_o unchanged. Re-arm in the same cycle as a trigger pulse -> trigger ignored, wptr_o=0.
6. trig_sel_i=0 with all trig_vec_i bits pulsing for 1000 cycles in WAIT -> never triggers. Then trig_sel_i=9 (>NTRG) -> never triggers.
